hazard_controller: RTL and testbench

Pipeline sequencing controller for the in-order RV32I core. It sits beside the decode stage and tracks destination registers in flight between decode and writeback. It stalls fetch/decode on read-after-write hazards, since the core has no forwarding. It also flushes the IF/ID slot after a taken jump resolves in EX. Decode consumes its outputs to issue bubbles (ALU_NONE, do_not_execute) instead of real instructions.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_controller_inflight_tracker.sv | 58 +++++
 rtl/hazard_controller.sv | 103 ++++++++++
 tb/tb_hazard_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32I hazard controller and its in-flight tracker.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
  } inflight_t;

  typedef enum logic [0:0] {
    CTRL_RUN   = 1'b0,
    CTRL_FLUSH = 1'b1
  } ctrl_state_e;

  // One-hot register decode; x0 is still decoded, callers never mark it valid.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] onehot;
    onehot       = '0;
    onehot[addr] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/hazard_controller_inflight_tracker.sv
// Destination-register pipeline from decode issue to writeback, with source-match
// detection against all stages except writeback and a pending-write bitmap.
module inflight_tracker
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_issue,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic                  i_rs1_en,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic                  i_rs2_en,
  output logic                  o_match,
  output logic [NUM_REGS-1:0]   o_pending_mask
);

  inflight_t [NUM_STAGES-1:0] r_entry;
  logic      [NUM_STAGES-2:0] w_hit;
  logic                       w_rs1_live;
  logic                       w_rs2_live;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_entry <= '0;
    end else begin
      r_entry[0].valid <= i_issue;
      r_entry[0].rd    <= i_issue ? i_issue_rd : '0;
      for (int i = 1; i < NUM_STAGES; i++) begin
        r_entry[i] <= r_entry[i-1];
      end
    end
  end

  assign w_rs1_live = i_rs1_en && (i_rs1_addr != '0);
  assign w_rs2_live = i_rs2_en && (i_rs2_addr != '0);

  // The writeback stage is excluded: the register file is write-through.
  for (genvar gi = 0; gi < NUM_STAGES - 1; gi++) begin : g_hit
    assign w_hit[gi] = r_entry[gi].valid &&
                       ((w_rs1_live && (i_rs1_addr == r_entry[gi].rd)) ||
                        (w_rs2_live && (i_rs2_addr == r_entry[gi].rd)));
  end

  assign o_match = |w_hit;

  always_comb begin
    o_pending_mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (r_entry[i].valid) begin
        o_pending_mask = o_pending_mask | reg_onehot(r_entry[i].rd);
      end
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Decode-side sequencing: stalls on RAW hazards (no forwarding), kills IF/ID after
// taken jumps, and counts stall cycles.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int NUM_WB_STAGES = 3,
  parameter int FLUSH_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
  input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
  input  logic                  dec_rs1_rd_en,
  input  logic                  dec_rs2_rd_en,
  input  logic [REG_ADDR_W-1:0] dec_rd_addr,
  input  logic                  dec_rd_wr_en,
  input  logic                  ex_jump_taken,
  output logic                  stall_fetch,
  output logic                  inject_bubble,
  output logic                  flush_if_id,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [15:0]           stall_count
);

  localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [CNT_W-1:0] FLUSH_RELOAD =
    (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;

  ctrl_state_e      r_state;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [15:0]      r_stall_count;

  logic w_flushing;
  logic w_match;
  logic w_raw_hazard;
  logic w_issue;

  assign w_flushing   = ex_jump_taken || (r_state == CTRL_FLUSH);
  assign w_raw_hazard = dec_valid && !w_flushing && w_match;
  // rd_wr_en should already be low for x0; the address check guards against sloppy decode.
  assign w_issue      = dec_valid && dec_rd_wr_en && (dec_rd_addr != '0) &&
                        !w_raw_hazard && !w_flushing;

  inflight_tracker #(
    .NUM_STAGES (NUM_WB_STAGES)
  ) u_tracker (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_issue        (w_issue),
    .i_issue_rd     (dec_rd_addr),
    .i_rs1_addr     (dec_rs1_addr),
    .i_rs1_en       (dec_rs1_rd_en),
    .i_rs2_addr     (dec_rs2_addr),
    .i_rs2_en       (dec_rs2_rd_en),
    .o_match        (w_match),
    .o_pending_mask (pending_mask)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= CTRL_RUN;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        CTRL_RUN: begin
          if (ex_jump_taken && (FLUSH_CYCLES > 1)) begin
            r_state     <= CTRL_FLUSH;
            r_flush_cnt <= FLUSH_RELOAD;
          end
        end
        CTRL_FLUSH: begin
          // A second jump landing mid-flush restarts the kill window.
          if (ex_jump_taken) begin
            r_flush_cnt <= FLUSH_RELOAD;
          end else if (r_flush_cnt == '0) begin
            r_state <= CTRL_RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: begin
          r_state     <= CTRL_RUN;
          r_flush_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= '0;
    end else if (w_raw_hazard && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_fetch   = w_raw_hazard;
  assign inject_bubble = w_raw_hazard || w_flushing;
  assign flush_if_id   = w_flushing;
  assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized scoreboard bench for hazard_controller, plus a deep-pipeline instance
// used to reach stall-counter saturation.
module tb_hazard_controller;

  localparam int NWB  = 3;
  localparam int NFL  = 2;
  localparam int SATN = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dec_valid;
  logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic        dec_rs1_rd_en, dec_rs2_rd_en, dec_rd_wr_en, ex_jump_taken;
  logic        stall_fetch, inject_bubble, flush_if_id;
  logic [31:0] pending_mask;
  logic [15:0] stall_count;

  logic        sat_rst_n;
  logic        sat_valid;
  logic        sat_jump;
  logic        sat_stall, sat_bubble, sat_flush;
  logic [31:0] sat_pending;
  logic [15:0] sat_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_controller #(.NUM_WB_STAGES(NWB), .FLUSH_CYCLES(NFL)) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dec_valid     (dec_valid),
    .dec_rs1_addr  (dec_rs1_addr),
    .dec_rs2_addr  (dec_rs2_addr),
    .dec_rs1_rd_en (dec_rs1_rd_en),
    .dec_rs2_rd_en (dec_rs2_rd_en),
    .dec_rd_addr   (dec_rd_addr),
    .dec_rd_wr_en  (dec_rd_wr_en),
    .ex_jump_taken (ex_jump_taken),
    .stall_fetch   (stall_fetch),
    .inject_bubble (inject_bubble),
    .flush_if_id   (flush_if_id),
    .pending_mask  (pending_mask),
    .stall_count   (stall_count)
  );

  hazard_controller #(.NUM_WB_STAGES(SATN), .FLUSH_CYCLES(1)) u_sat (
    .clk           (clk),
    .reset_n       (sat_rst_n),
    .dec_valid     (sat_valid),
    .dec_rs1_addr  (5'd1),
    .dec_rs2_addr  (5'd0),
    .dec_rs1_rd_en (1'b1),
    .dec_rs2_rd_en (1'b0),
    .dec_rd_addr   (5'd1),
    .dec_rd_wr_en  (1'b1),
    .ex_jump_taken (sat_jump),
    .stall_fetch   (sat_stall),
    .inject_bubble (sat_bubble),
    .flush_if_id   (sat_flush),
    .pending_mask  (sat_pending),
    .stall_count   (sat_count)
  );

  typedef struct {
    int          cyc;
    logic        sf;
    logic        ib;
    logic        fl;
    logic [31:0] pm;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: writes in flight are remembered by the cycle they issued.
  int          m_now = 0;
  int          m_iss_cyc[$];
  logic [4:0]  m_iss_rd[$];
  int          m_flush_end = -100;
  int          m_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive_cycle(input logic rst_v, input logic dv,
                             input logic [4:0] rs1, input logic e1,
                             input logic [4:0] rs2, input logic e2,
                             input logic [4:0] rd, input logic we, input logic jmp);
    exp_t        e;
    logic        match;
    logic        fl;
    logic        raw;
    logic [31:0] pm;
    int          age;
    @(posedge clk);
    #1;
    reset_n = rst_v; dec_valid = dv;
    dec_rs1_addr = rs1; dec_rs1_rd_en = e1;
    dec_rs2_addr = rs2; dec_rs2_rd_en = e2;
    dec_rd_addr = rd; dec_rd_wr_en = we; ex_jump_taken = jmp;
    if (!rst_v) begin
      m_iss_cyc.delete(); m_iss_rd.delete();
      m_flush_end = -100; m_count = 0;
    end
    pm = '0; match = 1'b0;
    for (int i = 0; i < m_iss_cyc.size(); i++) begin
      age = m_now - m_iss_cyc[i];
      if (age >= 1 && age <= NWB) pm[m_iss_rd[i]] = 1'b1;
      if (age >= 1 && age <= NWB - 1) begin
        if ((e1 && rs1 != 5'd0 && rs1 == m_iss_rd[i]) ||
            (e2 && rs2 != 5'd0 && rs2 == m_iss_rd[i])) match = 1'b1;
      end
    end
    fl  = jmp || (m_now <= m_flush_end);
    raw = dv && !fl && match;
    e.cyc = m_now; e.sf = raw; e.ib = raw || fl; e.fl = fl; e.pm = pm;
    e.sc = 16'(m_count);
    exp_q.push_back(e);
    if (rst_v) begin
      if (dv && we && rd != 5'd0 && !raw && !fl) begin
        m_iss_cyc.push_back(m_now); m_iss_rd.push_back(rd);
      end
      if (jmp) m_flush_end = m_now + NFL - 1;
      if (raw && m_count < 65535) m_count++;
    end
    m_now++;
    while (m_iss_cyc.size() > 0 && (m_now - m_iss_cyc[0]) > NWB) begin
      void'(m_iss_cyc.pop_front()); void'(m_iss_rd.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Monitor: the DUT presents a response every cycle; compare it mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("txn %0d: sf=%b ib=%b fl=%b pm=%h sc=%0d", e.cyc, stall_fetch,
               inject_bubble, flush_if_id, pending_mask, stall_count);
      chk("stall_fetch",   {31'd0, stall_fetch},   {31'd0, e.sf});
      chk("inject_bubble", {31'd0, inject_bubble}, {31'd0, e.ib});
      chk("flush_if_id",   {31'd0, flush_if_id},   {31'd0, e.fl});
      chk("pending_mask",  pending_mask,           e.pm);
      chk("stall_count",   {16'd0, stall_count},   {16'd0, e.sc});
    end
  end

  task automatic main_seq();
    // Reset with random inputs, then idle.
    for (int i = 0; i < 4; i++)
      drive_cycle(1'b0, 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                  1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
    idle(2);
    // addi x1 ; add x2,x1,x3 back-to-back.
    drive_cycle(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0);
    idle(4);
    // Writer to x0 then reader of x0.
    drive_cycle(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0);
    idle(2);
    // Single jump with a writer decoded through the kill window.
    drive_cycle(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    idle(4);
    // RAW hazard coinciding with a jump.
    drive_cycle(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    idle(4);
    // Two sources matching two different producers.
    drive_cycle(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0);
    idle(2);
    // Reset mid-flush and mid-stall.
    drive_cycle(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(2);
    drive_cycle(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
    idle(2);
    // Random traffic over a small register window so hazards are frequent.
    for (int i = 0; i < 1500; i++)
      drive_cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 8),
                  5'($urandom_range(0, 4)), 1'($urandom), 5'($urandom_range(0, 4)),
                  1'($urandom), 5'($urandom_range(0, 4)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0));
    idle(3);
  endtask

  // Deep pipeline (31 hazard cycles per 32) to reach counter saturation.
  task automatic sat_seq();
    int exp_cnt;
    logic exp_stall;
    exp_cnt = 0;
    @(posedge clk); #1;
    sat_rst_n = 1'b1; sat_valid = 1'b1;
    for (int c = 0; c < 67800; c++) begin
      exp_stall = ((c % SATN) != 0);
      @(negedge clk);
      n_cmp++;
      if (sat_stall !== exp_stall) begin
        n_err++;
        $display("FAIL sat_stall cycle %0d: got %b expected %b", c, sat_stall, exp_stall);
      end
      if ((c % 4096) == 0) chk("sat_count_progress", {16'd0, sat_count}, 32'(exp_cnt));
      if (exp_stall && exp_cnt < 65535) exp_cnt++;
    end
    @(negedge clk);
    chk("sat_count_saturated", {16'd0, sat_count}, 32'h0000_FFFF);
    @(posedge clk); #1;
    sat_rst_n = 1'b0;
    #2;
    chk("sat_count_async_reset", {16'd0, sat_count}, 32'd0);
    @(posedge clk); #1;
    sat_rst_n = 1'b1; sat_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; dec_valid = 1'b0;
    dec_rs1_addr = '0; dec_rs2_addr = '0; dec_rd_addr = '0;
    dec_rs1_rd_en = 1'b0; dec_rs2_rd_en = 1'b0; dec_rd_wr_en = 1'b0; ex_jump_taken = 1'b0;
    sat_rst_n = 1'b0; sat_valid = 1'b0; sat_jump = 1'b0;
    fork
      main_seq();
      sat_seq();
    join
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
